// File: rtl/mult_row_accum.sv
// mult_row_accum: accumulates a row of 2*DW-bit partial products coming out of
// a fixed-latency pipelined multiplier into a multi-word result. It emits one
// DW-bit result word per product, and the final high word with the last one.
// Operand sideband is carried through a delay line that is matched to the
// multiplier latency, so the products themselves need no valid signal.
module mult_row_accum #(
    parameter int unsigned DW  = 128,
    parameter int unsigned LAT = 3,
    parameter int unsigned CW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [DW-1:0] ret,
    input  logic [DW-1:0] carry,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [DW-1:0] out_word,
    output logic [DW-1:0] out_hi,
    output logic          out_last,
    output logic [CW-1:0] out_idx,
    output logic          err
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    // Sideband delay line, one {v, f, l} entry per multiplier pipeline stage
    logic [2:0]      sb [LAT];
    logic            av, af, al;

    logic            state, state_d;
    logic [2*DW-1:0] acc, acc_d;
    logic [2*DW-1:0] p, sum;
    logic            valid_d, last_d;
    logic [DW-1:0]   word_d, hi_d;
    logic [CW-1:0]   idx_d;
    logic            err_set, err_d;

    assign av = sb[LAT-1][2];
    assign af = sb[LAT-1][1];
    assign al = sb[LAT-1][0];
    assign p  = {carry, ret};

    // Shift operand sideband along so it lines up with {carry, ret}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= {in_valid, in_valid & in_first, in_valid & in_last};
            for (int unsigned i = 1; i < LAT; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Row FSM: a first product restarts the row (from either state); a
    // non-first product accumulates in ACCUM and is a protocol error in IDLE
    always_comb begin
        state_d = state;
        acc_d   = acc;
        word_d  = out_word;
        hi_d    = out_hi;
        idx_d   = out_idx;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_set = 1'b0;
        sum     = '0;
        if (av) begin
            if (af) begin
                // A first inside an open row abandons it; the restart
                // uses p alone so no carry leaks from the dropped row.
                err_set = (state == ST_ACCUM);
                sum     = p;
                valid_d = 1'b1;
                word_d  = sum[DW-1:0];
                idx_d   = '0;
                acc_d   = sum >> DW;
                if (al) begin
                    last_d  = 1'b1;
                    hi_d    = sum[2*DW-1:DW];
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end else if (state == ST_ACCUM) begin
                sum     = acc + p;
                valid_d = 1'b1;
                word_d  = sum[DW-1:0];
                idx_d   = out_idx + CW'(1);
                acc_d   = sum >> DW;
                if (al) begin
                    last_d  = 1'b1;
                    hi_d    = sum[2*DW-1:DW];
                    state_d = ST_IDLE;
                end
            end else begin
                err_set = 1'b1;
            end
        end
        err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err);
    end

    // Register FSM state, accumulator, outputs and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_word  <= '0;
            out_hi    <= '0;
            out_idx   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            out_word  <= word_d;
            out_hi    <= hi_d;
            out_idx   <= idx_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mult_row_accum.sv
// Scoreboard bench for mult_row_accum. A 3-stage multiplier model feeds the
// DUT; stimulus pushes hand-computed expected words, and a monitor pops and
// compares them whenever out_valid is seen.
module tb_mult_row_accum;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_first, in_last, clr_err;
    logic [DW-1:0] ret, carry;
    logic          out_valid, out_last, err;
    logic [DW-1:0] out_word, out_hi;
    logic [CW-1:0] out_idx;

    logic [DW-1:0]   x, y;
    logic [2*DW-1:0] m1 = '0, m2 = '0, m3 = '0;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] hi;
        logic          last;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [DW-1:0] M = '1;

    mult_row_accum #(.DW(DW), .LAT(3), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .ret      (ret),
        .carry    (carry),
        .clr_err  (clr_err),
        .out_valid(out_valid),
        .out_word (out_word),
        .out_hi   (out_hi),
        .out_last (out_last),
        .out_idx  (out_idx),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Multiplier model: 3-cycle latency, no reset, no valid
    always @(posedge clk) begin
        m1 <= {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        m2 <= m1;
        m3 <= m2;
    end
    assign ret   = m3[DW-1:0];
    assign carry = m3[2*DW-1:DW];

    task automatic check(input string name, input logic [2*DW-1:0] act,
                         input logic [2*DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [DW-1:0] w, input logic [DW-1:0] h,
                        input logic l, input logic [CW-1:0] i);
        exp_t e;
        e.word = w; e.hi = h; e.last = l; e.idx = i;
        q.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] xv, input logic [DW-1:0] yv,
                        input logic f, input logic l);
        x = xv; y = yv; in_valid = 1'b1; in_first = f; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        check("drain_queue_empty", 256'(q.size()), 256'(0));
        idle(3);
    endtask

    // Monitor: every out_valid must match the next expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 256'(1), 256'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_word", 256'(out_word), 256'(e.word));
                check("out_idx", 256'(out_idx), 256'(e.idx));
                check("out_last", 256'(out_last), 256'(e.last));
                if (e.last) check("out_hi", 256'(out_hi), 256'(e.hi));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        clr_err = 1'b0; x = '0; y = '0;
        idle(2);
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_out_word", 256'(out_word), 256'(0));
        check("reset_out_idx", 256'(out_idx), 256'(0));
        check("reset_err", 256'(err), 256'(0));
        rst_n = 1'b1;
        idle(2);

        // Single-product row, with latency check
        push(128'd35, 128'd0, 1'b1, 6'd0);
        send(128'd5, 128'd7, 1'b1, 1'b1);
        idle(2);
        check("latency_not_early", 256'(out_valid), 256'(0));
        idle(1);
        check("latency_at_4", 256'(out_valid), 256'(1));
        drain();

        // All-ones three-product row, back to back
        push(128'd1, '0, 1'b0, 6'd0);
        push(M, '0, 1'b0, 6'd1);
        push(M, M - 128'd1, 1'b1, 6'd2);
        send(M, M, 1'b1, 1'b0);
        send(M, M, 1'b0, 1'b0);
        send(M, M, 1'b0, 1'b1);
        drain();

        // Same row with a two-cycle bubble after the first product
        push(128'd1, '0, 1'b0, 6'd0);
        push(M, '0, 1'b0, 6'd1);
        push(M, M - 128'd1, 1'b1, 6'd2);
        send(M, M, 1'b1, 1'b0);
        idle(2);
        send(M, M, 1'b0, 1'b0);
        send(M, M, 1'b0, 1'b1);
        drain();

        // Back-to-back single-product rows
        push(128'd12, 128'd0, 1'b1, 6'd0);
        push(128'd1, 128'd0, 1'b1, 6'd0);
        send(128'd3, 128'd4, 1'b1, 1'b1);
        send(128'd1, 128'd1, 1'b1, 1'b1);
        drain();

        // 66-product row: out_idx wraps from 63 to 0 without error
        for (int i = 0; i < 66; i++) begin
            push(DW'(i + 1), 128'd0, (i == 65), CW'(i));
            send(DW'(i + 1), 128'd1, (i == 0), (i == 65));
        end
        drain();
        check("wrap_no_err", 256'(err), 256'(0));

        // Non-first product in IDLE: dropped, err set
        send(128'd2, 128'd3, 1'b0, 1'b0);
        drain();
        check("err_idle_nonfirst", 256'(err), 256'(1));
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        check("err_cleared", 256'(err), 256'(0));

        // First in the middle of a row: err set, restart at idx 0
        push(128'd1, 128'd0, 1'b0, 6'd0);
        push(128'd2, 128'd0, 1'b1, 6'd0);
        send(128'd1, 128'd1, 1'b1, 1'b0);
        send(128'd2, 128'd1, 1'b1, 1'b1);
        drain();
        check("err_midrow_first", 256'(err), 256'(1));
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        check("err_cleared_2", 256'(err), 256'(0));

        // clr_err coinciding with a new error: set wins
        send(128'd2, 128'd3, 1'b0, 1'b0);
        idle(2);
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        check("err_set_beats_clr", 256'(err), 256'(1));

        // Reset mid-row: in-flight products never surface
        send(128'd9, 128'd9, 1'b1, 1'b0);
        send(128'd9, 128'd9, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_out_word", 256'(out_word), 256'(0));
        check("midrst_out_idx", 256'(out_idx), 256'(0));
        check("midrst_err", 256'(err), 256'(0));
        idle(1);
        rst_n = 1'b1;
        idle(5);
        push(128'd20, 128'd0, 1'b0, 6'd0);
        push(128'd6, 128'd0, 1'b1, 6'd1);
        send(128'd4, 128'd5, 1'b1, 1'b0);
        send(128'd6, 128'd1, 1'b0, 1'b1);
        drain();
        check("post_reset_err", 256'(err), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_row_accum.md
Name: mult_row_accum

Overview:
- Downstream consumer of the 128x128 pipelined multiplier (3-cycle latency, outputs {carry, ret}, no valid or enable).
- Accumulates a row of partial products p_i = x_i * y into one multi-word result, where result = sum of p_i << (i*DW).
- Emits the result one DW-bit word per accepted product, plus the final high word on the last product.
- Tracks operand sideband (valid/first/last) through a delay line matched to the multiplier latency, so products need no valid of their own.

Parameters:
- DW, 128, word width; also the width of ret and carry.
- LAT, 3, multiplier latency in cycles, from operands at the multiplier input to {carry, ret}.
- CW, 6, width of the output word index counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair presented to the multiplier this cycle
- in_first  input  1  qualifies in_valid; first product of a row
- in_last  input  1  qualifies in_valid; last product of a row (may coincide with in_first)
- ret  input  DW  multiplier product, low half
- carry  input  DW  multiplier product, high half
- clr_err  input  1  synchronous clear of err
- out_valid  output  1  out_word (and out_hi when out_last) valid this cycle
- out_word  output  DW  result word number out_idx
- out_hi  output  DW  final high result word; meaningful only when out_last=1
- out_last  output  1  final word of the row
- out_idx  output  CW  index of out_word within the row
- err  output  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_last=0, out_word=0, out_hi=0, out_idx=0, err=0, state=IDLE, accumulator=0, all delay-line bits=0.
- Sideband delay line:
  - LAT-stage shift register of {v, f, l}, each stage loaded with {in_valid, in_valid&in_first, in_valid&in_last}.
  - The stage-LAT output (av, af, al) is aligned with {carry, ret}.
- Accumulator: acc is a 2*DW-bit register, and p = {carry, ret}.
  - No overflow is possible: (acc>>DW) + p < 2^(2DW). No guard bits.
- FSM has two states, IDLE and ACCUM.
- IDLE:
  - av&af: sum = p; out_word = sum[DW-1:0]; out_idx = 0; out_valid = 1; acc <= sum >> DW.
    - If al: out_last = 1, out_hi = sum[2DW-1:DW], stay IDLE.
    - Otherwise go to ACCUM.
  - av&!af: product dropped, no output, err <= 1, stay IDLE.
- ACCUM:
  - av&!af: sum = acc + p; emit sum[DW-1:0] with out_idx = previous out_idx + 1; acc <= sum >> DW.
    - If al: out_last = 1, out_hi = sum[2DW-1:DW], go to IDLE.
  - av&af: err <= 1; the row is abandoned and restarted exactly as in IDLE with af. The emitted word has out_idx = 0 and no carry from the abandoned row.
  - !av: bubble. Hold acc and out_idx, out_valid = 0. Gaps inside a row are legal.
- Latency: out_valid is registered, asserting LAT+1 = 4 cycles after the matching in_valid. Throughput is one product per cycle, with no stall and no backpressure.
- Back-to-back rows: in_last at cycle n and in_first at cycle n+1 are legal. The new row starts from acc = p only, with no carry leak from the previous row.
- out_idx wraps modulo 2^CW with no error.
- err:
  - Set has priority over clr_err in the same cycle.
  - Otherwise clr_err clears err.
  - Protocol errors set err only; data flow continues as described above.
- out_word/out_hi/out_idx hold their last values while out_valid = 0.
- Reset mid-row: everything returns to reset values immediately. Products already in the multiplier pipeline are ignored because the delay line was cleared.

Test Plan:
- Single-product row: x=5, y=7, in_first=in_last=1 -> 4 cycles later one pulse with out_valid=1, out_word=35, out_hi=0, out_last=1, out_idx=0.
- Three-word row, all-ones operands: x_i = y = 2^128-1 for i=0..2 -> words 1, 2^128-1, 2^128-1 at idx 0, 1, 2, then out_hi=2^128-2 with out_last on idx 2. This equals (2^384-1)*(2^128-1).
- Bubbles inside a row: same row as above with 2 idle cycles between products 0 and 1 -> identical words, out_valid low during the gaps, acc preserved.
- Back-to-back rows: row A (x=3, y=4, first+last) immediately followed by row B (x=1, y=1, first+last) -> out_word 12 then 1 on consecutive cycles, both with out_hi=0.
- Protocol errors:
  - in_valid without in_first in IDLE -> no output, err=1.
  - in_first mid-row -> err=1 and output restarts at idx 0.
  - clr_err -> err=0.
  - clr_err in the same cycle as a new error -> err stays 1.
- Reset mid-row: rst_n low for 1 cycle after 2 of 4 products -> outputs 0 asynchronously. No out_valid from the in-flight products. A new row afterwards is correct from idx 0.
